eth_tx_arbiter: RTL and testbench
=================================

Name: eth_tx_arbiter

Overview:
- Shares the single MII transmit path (4-bit nibble bus, one nibble per eth_tx_clk) between two frame sources: the ARP-reply generator and the UDP/IP frame sender.
- Grants the PHY to one requester for a whole frame, muxes and registers that requester's nibble stream onto eth_tx_en/eth_tx_data, then enforces the Ethernet inter-frame gap.
- Sits between the ARP/UDP send modules and the PHY transmit pins in the ethernet top level.

Parameters:
- IFG_NIBBLES, 24, inter-frame gap length in clock cycles (12 bytes x 2 nibbles).
- TIMEOUT_CYCLES, 4096, maximum grant duration before the grant is forcibly revoked.
- CNT_W, 13, width of the shared gap/timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- sys_clk  in  1  transmit clock (eth_tx_clk domain).
- sys_rst_n  in  1  reset; asynchronous, active-low.
- arp_req  in  1  ARP source requests the PHY; level, held until granted.
- arp_tx_en  in  1  ARP source nibble valid.
- arp_tx_data  in  4  ARP source nibble.
- arp_done  in  1  ARP source end-of-frame; 1-cycle pulse.
- udp_req  in  1  UDP source requests the PHY; level, held until granted.
- udp_tx_en  in  1  UDP source nibble valid.
- udp_tx_data  in  4  UDP source nibble.
- udp_done  in  1  UDP source end-of-frame; 1-cycle pulse.
- arp_gnt  out  1  ARP source owns the PHY.
- udp_gnt  out  1  UDP source owns the PHY.
- eth_tx_en  out  1  to PHY.
- eth_tx_data  out  4  to PHY.
- timeout_err  out  1  1-cycle pulse when a grant is revoked by the watchdog.

Behaviour:
- Reset (async, immediate): state=IDLE; arp_gnt, udp_gnt, eth_tx_en, timeout_err=0; eth_tx_data=4'h0; last_owner=UDP, so ARP wins the first tie; counter=0. Reset mid-frame truncates the output immediately, with no flush.
- States:
  - IDLE: no grant; the outputs drive 0.
  - GNT_ARP / GNT_UDP: the named source owns the PHY.
  - IFG: gap; the outputs drive 0.
- IDLE transitions:
  - If only one req is high, go to that source's GNT state.
  - If both are high, grant the source that is not last_owner (round-robin).
  - The gnt output rises on the cycle after the req is sampled.
- GNT_x, each cycle:
  - eth_tx_en <= x_tx_en; eth_tx_data <= x_tx_en ? x_tx_data : 0. This gives one cycle of registered latency.
  - The non-granted source's tx_en/tx_data/done inputs are ignored.
- Frame end (x_done=1 in GNT_x): next state IFG. Clear gnt, set last_owner=x, load counter=0. The nibble sampled together with done is still forwarded.
- Watchdog: the counter increments every GNT cycle. When it reaches TIMEOUT_CYCLES-1 without done, go to IFG, pulse timeout_err for 1 cycle, set last_owner=x and force eth_tx_en=0 on the next cycle. If done and the timeout coincide, done wins and timeout_err stays 0.
- IFG: the counter increments each cycle. After exactly IFG_NIBBLES cycles with eth_tx_en=0, go to IDLE. Requests are not sampled during IFG.
- Minimum spacing: from the last forwarded nibble to the first nibble of the next frame is ≥ IFG_NIBBLES+2 cycles of eth_tx_en=0 (IFG plus IDLE decision plus grant register).
- At most one gnt is high at any time. The gnt outputs are never high in IDLE or IFG.
- A req dropped before grant is simply not served. A req dropped during GNT has no effect; only done or the timeout ends the grant.

Decomposition:
- Package eth_pkg holds:
  - typedef enum tx_arb_state_t {IDLE, GNT_ARP, GNT_UDP, IFG};
  - typedef enum logic owner_t {OWN_ARP, OWN_UDP};
  - localparam ETH_IFG_NIBBLES=24, shared with the frame senders.
- No sub-module is needed. The single counter is reused for the watchdog and the IFG, and the mux is inline.

Test Plan:
- Single ARP frame: arp_req with 120 nibbles and arp_done on the last one → arp_gnt=1 one cycle after req; eth_tx_data equals the ARP nibbles delayed 1 cycle; then 24 cycles of eth_tx_en=0 before IDLE.
- Simultaneous arp_req and udp_req out of reset → ARP granted first. After arp_done plus IFG, UDP is granted. Repeat the pair: UDP is granted first this time, confirming round-robin.
- UDP request arrives during ARP IFG → udp_gnt is not asserted until IFG completes. Measured gap between frames on eth_tx_en is ≥ 26 cycles.
- Granted UDP source never pulses done → exactly at 4096 GNT cycles: timeout_err pulses once, udp_gnt falls, eth_tx_en=0, IFG follows.
- Non-granted ARP drives arp_tx_en=1 and data 4'hF during a UDP grant → eth_tx_data matches UDP only; the assertion "arp_gnt & udp_gnt never both 1" holds.
- sys_rst_n asserted mid-UDP-frame (nibble 60) → all outputs 0 in the same time step. After release, a pending udp_req is granted fresh, starting from IDLE.

Source files
------------

// File: rtl/eth_pkg.sv
// rtl/eth_pkg.sv - shared Ethernet transmit types and constants
// Purpose: state and owner encodings for the MII transmit arbiter, plus the
//          inter-frame gap length that the frame senders also rely on.
// Ports:   none (package).
package eth_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GNT_ARP,
    GNT_UDP,
    IFG
  } tx_arb_state_t;

  typedef enum logic {
    OWN_ARP,
    OWN_UDP
  } owner_t;

  // 12 byte times on a nibble-wide MII bus.
  localparam int ETH_IFG_NIBBLES = 24;

endpackage

// File: rtl/eth_tx_arbiter.sv
// rtl/eth_tx_arbiter.sv - two-source MII transmit arbiter with IFG and watchdog
// Purpose: grants the single MII transmit path to the ARP-reply generator or
//          the UDP/IP sender for one whole frame, registers the owner's nibble
//          stream onto the PHY pins, then holds the bus idle for the
//          inter-frame gap. A watchdog revokes a grant that never ends.
// Ports:
//   sys_clk, sys_rst_n          transmit clock; async active-low reset
//   arp_req/udp_req             level requests, held until granted
//   arp_tx_en/arp_tx_data       ARP nibble stream
//   udp_tx_en/udp_tx_data       UDP nibble stream
//   arp_done/udp_done           end-of-frame pulse on the last nibble
//   arp_gnt/udp_gnt             current owner of the PHY
//   eth_tx_en/eth_tx_data       registered MII transmit outputs
//   timeout_err                 1-cycle pulse when the watchdog revokes a grant
module eth_tx_arbiter
  import eth_pkg::*;
#(
  parameter int IFG_NIBBLES    = ETH_IFG_NIBBLES,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int CNT_W          = 13
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       arp_req,
  input  logic       arp_tx_en,
  input  logic [3:0] arp_tx_data,
  input  logic       arp_done,
  input  logic       udp_req,
  input  logic       udp_tx_en,
  input  logic [3:0] udp_tx_data,
  input  logic       udp_done,
  output logic       arp_gnt,
  output logic       udp_gnt,
  output logic       eth_tx_en,
  output logic [3:0] eth_tx_data,
  output logic       timeout_err
);

  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] IFG_LAST = CNT_W'(IFG_NIBBLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  tx_arb_state_t    state, state_nx;
  owner_t           last_owner, last_owner_nx;
  owner_t           own;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             tx_en_nx, timeout_nx;
  logic [3:0]       tx_data_nx;
  logic             sel_en, sel_done;
  logic [3:0]       sel_data;

  // Only the granted source is looked at; the other one's stream is don't-care.
  assign sel_en   = (state == GNT_ARP) ? arp_tx_en   : udp_tx_en;
  assign sel_data = (state == GNT_ARP) ? arp_tx_data : udp_tx_data;
  assign sel_done = (state == GNT_ARP) ? arp_done    : udp_done;
  assign own      = (state == GNT_ARP) ? OWN_ARP     : OWN_UDP;

  // Grants come straight from the state register, so they are never high in
  // IDLE or IFG and can never both be high.
  assign arp_gnt = (state == GNT_ARP);
  assign udp_gnt = (state == GNT_UDP);

  always_comb begin
    state_nx      = state;
    last_owner_nx = last_owner;
    cnt_nx        = cnt;
    tx_en_nx      = 1'b0;
    tx_data_nx    = 4'h0;
    timeout_nx    = 1'b0;
    case (state)
      IDLE: begin
        cnt_nx = '0;
        // On a tie the source that did not transmit last wins.
        if (arp_req && (!udp_req || last_owner == OWN_UDP)) begin
          state_nx = GNT_ARP;
        end else if (udp_req) begin
          state_nx = GNT_UDP;
        end
      end
      GNT_ARP, GNT_UDP: begin
        tx_en_nx   = sel_en;
        tx_data_nx = sel_en ? sel_data : 4'h0;
        cnt_nx     = cnt + CNT_ONE;
        // done is checked first so a frame ending on the last allowed cycle
        // is a normal completion, not a watchdog event.
        if (sel_done) begin
          state_nx      = IFG;
          last_owner_nx = own;
          cnt_nx        = '0;
        end else if (cnt == TO_LAST) begin
          state_nx      = IFG;
          last_owner_nx = own;
          cnt_nx        = '0;
          timeout_nx    = 1'b1;
          tx_en_nx      = 1'b0;
          tx_data_nx    = 4'h0;
        end
      end
      IFG: begin
        if (cnt == IFG_LAST) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CNT_ONE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state       <= IDLE;
      last_owner  <= OWN_UDP;
      cnt         <= '0;
      eth_tx_en   <= 1'b0;
      eth_tx_data <= 4'h0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nx;
      last_owner  <= last_owner_nx;
      cnt         <= cnt_nx;
      eth_tx_en   <= tx_en_nx;
      eth_tx_data <= tx_data_nx;
      timeout_err <= timeout_nx;
    end
  end

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// tb/tb_eth_tx_arbiter.sv - scoreboard bench for the MII transmit arbiter
module tb_eth_tx_arbiter;
  import eth_pkg::*;

  localparam int IFG      = 24;
  localparam int TO       = 4096;
  localparam int WAIT_MAX = 6000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       arp_req, arp_tx_en, arp_done;
  logic [3:0] arp_tx_data;
  logic       udp_req, udp_tx_en, udp_done;
  logic [3:0] udp_tx_data;
  logic       arp_gnt, udp_gnt, eth_tx_en, timeout_err;
  logic [3:0] eth_tx_data;

  always #5 clk = ~clk;

  eth_tx_arbiter #(
    .IFG_NIBBLES   (IFG),
    .TIMEOUT_CYCLES(TO),
    .CNT_W         (13)
  ) dut (
    .sys_clk    (clk),
    .sys_rst_n  (rst_n),
    .arp_req    (arp_req),
    .arp_tx_en  (arp_tx_en),
    .arp_tx_data(arp_tx_data),
    .arp_done   (arp_done),
    .udp_req    (udp_req),
    .udp_tx_en  (udp_tx_en),
    .udp_tx_data(udp_tx_data),
    .udp_done   (udp_done),
    .arp_gnt    (arp_gnt),
    .udp_gnt    (udp_gnt),
    .eth_tx_en  (eth_tx_en),
    .eth_tx_data(eth_tx_data),
    .timeout_err(timeout_err)
  );

  typedef struct {
    logic [3:0] data;
    int         cyc;
  } nib_t;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  nib_t exp_q[$];
  int   gnt_q[$];
  int   model_last = 1;

  int   fwd_count = 0, to_count = 0;
  int   last_gap = 0, last_gnt_len = 0, last_lat = 0;
  logic last_fall_to = 1'b0, last_fall_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Round-robin reference: a lone requester wins; on a tie the one that did
  // not own the bus last wins. 0 = ARP, 1 = UDP.
  function automatic int winner(input int a, input int u);
    if (a != 0 && u != 0) return (model_last == 1) ? 0 : 1;
    return (u != 0) ? 1 : 0;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input bit u, input logic e, input logic [3:0] d, input logic dn);
    if (u) begin
      udp_tx_en = e; udp_tx_data = d; udp_done = dn;
    end else begin
      arp_tx_en = e; arp_tx_data = d; arp_done = dn;
    end
  endtask

  task automatic set_req(input bit u, input logic r);
    if (u) udp_req = r;
    else   arp_req = r;
  endtask

  // Frame source: requests, waits for its grant, idles one cycle, then streams
  // len random nibbles (done on the last if with_done) while still granted.
  task automatic send_frame(input bit u, input int len, input bit with_done);
    int   lat;
    bit   got;
    logic g;
    nib_t n;
    @(negedge clk);
    set_req(u, 1'b1);
    lat = 0;
    got = 0;
    for (int i = 0; i < WAIT_MAX; i++) begin
      @(posedge clk);
      #1;
      lat++;
      g = u ? udp_gnt : arp_gnt;
      if (g) begin
        got = 1;
        break;
      end
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL gnt_wait actual=no_grant required=grant_within_%0d", WAIT_MAX);
      set_req(u, 1'b0);
      return;
    end
    last_lat = lat;
    @(negedge clk);
    set_req(u, 1'b0);
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      g = u ? udp_gnt : arp_gnt;
      if (!g) break;
      n.data = 4'($urandom);
      n.cyc  = cyc + 1;
      drive(u, 1'b1, n.data, (with_done && i == len - 1) ? 1'b1 : 1'b0);
      exp_q.push_back(n);
    end
    @(negedge clk);
    drive(u, 1'b0, 4'h0, 1'b0);
  endtask

  // Monitor: compares every forwarded nibble with the scoreboard and tracks
  // grant order, grant length, gaps and watchdog pulses.
  logic prev_gnt = 1'b0, had_en = 1'b0, seen_fall = 1'b0;
  int   zero_run = 0, gnt_len = 0, gnt_low = 0;

  always begin
    logic g;
    nib_t e;
    int   eo;
    @(posedge clk);
    #1;
    if (rst_n) begin
      check("both_gnt", 32'(arp_gnt & udp_gnt), 0);
      g = arp_gnt | udp_gnt;
      if (g && !prev_gnt) begin
        if (gnt_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL gnt_unexpected actual=arp%0d_udp%0d required=no_grant", arp_gnt, udp_gnt);
        end else begin
          eo = gnt_q.pop_front();
          check("gnt_owner_is_udp", 32'(udp_gnt), 32'(eo));
        end
        if (seen_fall) check("gnt_spacing_ok", 32'(gnt_low >= IFG + 1), 1);
        gnt_len = 0;
      end
      if (!g && prev_gnt) begin
        last_gnt_len = gnt_len;
        last_fall_to = timeout_err;
        last_fall_en = eth_tx_en;
        seen_fall    = 1'b1;
        gnt_low      = 0;
      end
      if (g) gnt_len++;
      else   gnt_low++;
      if (timeout_err) to_count++;
      if (eth_tx_en) begin
        if (had_en && zero_run > 0) begin
          last_gap = zero_run;
          check("frame_gap_ok", 32'(zero_run >= IFG + 2), 1);
        end
        zero_run = 0;
        had_en   = 1'b1;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL tx_unexpected actual=%0h required=no_nibble", eth_tx_data);
        end else begin
          e = exp_q.pop_front();
          check("tx_data", 32'(eth_tx_data), 32'(e.data));
          check("tx_cycle", 32'(cyc), 32'(e.cyc));
          fwd_count++;
        end
      end else begin
        zero_run++;
        check("idle_data_zero", 32'(eth_tx_data), 0);
      end
      prev_gnt = g;
    end else begin
      prev_gnt  = 1'b0;
      had_en    = 1'b0;
      zero_run  = 0;
      seen_fall = 1'b0;
    end
  end

  task automatic check_outputs_zero(input string tag);
    check({tag, "_tx_en"}, 32'(eth_tx_en), 0);
    check({tag, "_tx_data"}, 32'(eth_tx_data), 0);
    check({tag, "_arp_gnt"}, 32'(arp_gnt), 0);
    check({tag, "_udp_gnt"}, 32'(udp_gnt), 0);
    check({tag, "_timeout"}, 32'(timeout_err), 0);
  endtask

  initial begin
    int w, base;
    rst_n = 1'b0;
    arp_req = 0; arp_tx_en = 0; arp_tx_data = 0; arp_done = 0;
    udp_req = 0; udp_tx_en = 0; udp_tx_data = 0; udp_done = 0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    idle(5);

    // Simultaneous requests out of reset.
    w = winner(1, 1);
    gnt_q.push_back(w); gnt_q.push_back(1 - w); model_last = 1 - w;
    fork
      send_frame(1'b0, 60, 1'b1);
      send_frame(1'b1, 60, 1'b1);
    join
    check("pair1_gap", 32'(last_gap), IFG + 2);
    idle(30);

    // Single ARP frame.
    w = winner(1, 0);
    gnt_q.push_back(w); model_last = w;
    send_frame(1'b0, 120, 1'b1);
    check("arp_gnt_latency", 32'(last_lat), 1);
    idle(30);

    // Second simultaneous pair: ARP sent last, so UDP should lead.
    w = winner(1, 1);
    gnt_q.push_back(w); gnt_q.push_back(1 - w); model_last = 1 - w;
    fork
      send_frame(1'b0, 40, 1'b1);
      send_frame(1'b1, 40, 1'b1);
    join
    check("pair2_gap", 32'(last_gap), IFG + 2);
    idle(30);

    // UDP request arriving in the middle of the ARP gap.
    gnt_q.push_back(0); gnt_q.push_back(1); model_last = 1;
    fork
      send_frame(1'b0, 40, 1'b1);
      begin
        idle(50);
        send_frame(1'b1, 30, 1'b1);
      end
    join
    check("ifg_req_gap", 32'(last_gap), IFG + 2);
    idle(30);

    // Non-granted ARP drives junk during a UDP grant.
    gnt_q.push_back(1); model_last = 1;
    fork
      send_frame(1'b1, 50, 1'b1);
      begin
        idle(3);
        for (int i = 0; i < 45; i++) begin
          @(negedge clk);
          drive(1'b0, 1'b1, 4'hF, (i % 10 == 9) ? 1'b1 : 1'b0);
        end
        @(negedge clk);
        drive(1'b0, 1'b0, 4'h0, 1'b0);
      end
    join
    idle(30);

    // done lands on the final watchdog cycle: done must win.
    gnt_q.push_back(0); model_last = 0;
    send_frame(1'b0, TO - 1, 1'b1);
    idle(2);
    check("coincide_no_timeout", 32'(to_count), 0);
    check("coincide_gnt_len", 32'(last_gnt_len), TO);
    check("coincide_fall_to", 32'(last_fall_to), 0);
    check("coincide_drained", 32'(exp_q.size()), 0);
    idle(30);

    // UDP never signals done: watchdog revokes after TO grant cycles.
    gnt_q.push_back(1); model_last = 1;
    send_frame(1'b1, 5000, 1'b0);
    idle(2);
    check("timeout_pulses", 32'(to_count), 1);
    check("timeout_gnt_len", 32'(last_gnt_len), TO);
    check("timeout_at_fall", 32'(last_fall_to), 1);
    check("timeout_tx_en_off", 32'(last_fall_en), 0);
    check("timeout_dropped_nibble", 32'(exp_q.size()), 1);
    exp_q.delete();
    idle(30);

    // Reset in the middle of a UDP frame.
    gnt_q.push_back(1);
    base = fwd_count;
    fork
      send_frame(1'b1, 120, 1'b1);
    join_none
    for (int i = 0; i < 400 && fwd_count < base + 60; i++) @(posedge clk);
    check("reset_reached_nibble60", 32'(fwd_count >= base + 60), 1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("midrst");
    idle(4);
    exp_q.delete();
    model_last = 1;
    gnt_q.push_back(winner(0, 1)); model_last = 1;
    fork
      send_frame(1'b1, 20, 1'b1);
    join_none
    idle(3);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("fresh_gnt_after_reset", 32'(udp_gnt), 1);
    idle(80);
    check("end_exp_empty", 32'(exp_q.size()), 0);
    check("end_gnt_q_empty", 32'(gnt_q.size()), 0);
    check("end_timeout_total", 32'(to_count), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog actual=time_limit required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
